cache_snoop_responder: RTL and testbench



---
 rtl/Cache_struct.sv | 74 +++++++
 rtl/cache_snoop_fifo.sv | 70 +++++++
 rtl/cache_snoop_responder.sv | 178 +++++++++++++++++
 tb/tb_cache_snoop_responder.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/Cache_struct.sv
// Shared cache type definitions: MESI line states, bus operations, MESI-FSM
// n-messages, and the snoop-responder entry/state types.
package Cache_struct;

  localparam int SNP_ADDR_W = 32;

  typedef enum logic [1:0] {
    MESI_I = 2'b00,
    MESI_S = 2'b01,
    MESI_E = 2'b10,
    MESI_M = 2'b11
  } mesi_struct;

  typedef enum logic [2:0] {
    NULL       = 3'd0,
    READ       = 3'd1,
    WRITE      = 3'd2,
    INVALIDATE = 3'd3,
    RWIM       = 3'd4
  } bus_struct;

  typedef enum logic [2:0] {
    NMSG_NULL         = 3'd0,
    SNOOP_READ_REQ    = 3'd1,
    SNOOP_READ_WITH_M = 3'd2,
    SNOOP_WRITE_REQ   = 3'd3,
    SNOOP_INVALID_CMD = 3'd4
  } n_struct;

  localparam logic [1:0] HIT   = 2'b00;
  localparam logic [1:0] HITM  = 2'b01;
  localparam logic [1:0] NOHIT = 2'b10;

  typedef struct packed {
    bus_struct               op;
    logic [SNP_ADDR_W-1:0]   addr;
    logic                    own;
  } snp_entry_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    RESP   = 2'd2,
    WAITWB = 2'd3
  } snp_state_t;

  // Snoop result for a foreign operation given the line's MESI state.
  function automatic logic [1:0] snoop_result(bus_struct op, mesi_struct st);
    logic [1:0] r;
    r = NOHIT;
    if (op == READ || op == RWIM) begin
      case (st)
        MESI_M:         r = HITM;
        MESI_E, MESI_S: r = HIT;
        default:        r = NOHIT;
      endcase
    end
    return r;
  endfunction

  // n-message forwarded to the MESI FSM for a snooped operation.
  function automatic n_struct snoop_nmsg(bus_struct op);
    n_struct n;
    case (op)
      READ:       n = SNOOP_READ_REQ;
      RWIM:       n = SNOOP_READ_WITH_M;
      WRITE:      n = SNOOP_WRITE_REQ;
      INVALIDATE: n = SNOOP_INVALID_CMD;
      default:    n = NMSG_NULL;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/cache_snoop_fifo.sv
// Synchronous FIFO of pending snoops. ready is a registered not-full flag that
// is low during reset; a push while full is accepted only alongside a pop.
module cache_snoop_fifo
  import Cache_struct::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = snp_entry_t
) (
  input  logic   clk,
  input  logic   rstb,
  input  logic   push,
  input  entry_t din,
  input  logic   pop,
  output entry_t head,
  output logic   empty,
  output logic   ready
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW:0]   count_q, count_d;
  logic          ready_q, ready_d;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem_q[rptr_q];
  assign ready   = ready_q;

  // Pointer/occupancy next-state; pointers wrap naturally at a power-of-2 depth.
  always_comb begin
    wptr_d = do_push ? wptr_q + 1'b1 : wptr_q;
    rptr_d = do_pop  ? rptr_q + 1'b1 : rptr_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
    ready_d = (count_d != FULL_CNT);
  end

  // Pointer, occupancy and ready registers.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ready_q <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ready_q <= ready_d;
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din;
  end

endmodule

// File: rtl/cache_snoop_responder.sv
// Snoop responder: queues foreign bus operations, looks up the line state,
// drives the snoop result and forwards the SNOOP_* message to the MESI FSM.
//
//   state  | meaning
//   IDLE   | waiting for a queued snoop; pops the head when one is present
//   LOOKUP | tag/state lookup outstanding; times out to state I
//   RESP   | one-cycle result: c_out/c_out_valid, optional nmsg
//   WAITWB | HITM given; holding off further snoops until flush write is done
module cache_snoop_responder
  import Cache_struct::*;
#(
  parameter int ADDR_W     = 32,
  parameter int FIFO_DEPTH = 2,
  parameter int LKUP_TMO   = 8,
  parameter int WB_TMO     = 16
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              snp_valid,
  output logic              snp_ready,
  input  bus_struct         snp_op,
  input  logic [ADDR_W-1:0] snp_addr,
  input  logic              snp_own,
  output logic              lookup_req,
  output logic [ADDR_W-1:0] lookup_addr,
  input  logic              lookup_ack,
  input  mesi_struct        lookup_state,
  output logic [1:0]        c_out,
  output logic              c_out_valid,
  output n_struct           nmsg_out,
  output logic              nmsg_valid,
  input  logic              wb_done,
  output logic              busy,
  output logic              err
);

  localparam int MAX_TMO = (LKUP_TMO > WB_TMO) ? LKUP_TMO : WB_TMO;
  localparam int CNT_W   = $clog2(MAX_TMO);

  typedef struct packed {
    bus_struct         op;
    logic [ADDR_W-1:0] addr;
    logic              own;
  } entry_t;

  snp_state_t       state_q, state_d;
  entry_t           hold_q, hold_d;
  mesi_struct       res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  entry_t           fifo_din;
  entry_t           fifo_head;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_empty;
  logic [1:0]       res_code;

  // NULL operations are dropped at the input and never occupy a slot.
  assign fifo_din  = '{op: snp_op, addr: snp_addr, own: snp_own};
  assign fifo_push = snp_valid && snp_ready && (snp_op != NULL);

  cache_snoop_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (clk),
    .rstb  (rstb),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .head  (fifo_head),
    .empty (fifo_empty),
    .ready (snp_ready)
  );

  assign busy = (state_q != IDLE) || !fifo_empty;
  assign err  = err_q;

  // Next-state and output decode for the snoop sequence.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    res_d       = res_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    fifo_pop    = 1'b0;
    lookup_req  = 1'b0;
    lookup_addr = '0;
    res_code    = NOHIT;
    c_out       = NOHIT;
    c_out_valid = 1'b0;
    nmsg_out    = NMSG_NULL;
    nmsg_valid  = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          hold_d   = fifo_head;
          if (fifo_head.own) begin
            res_d   = MESI_I;
            state_d = RESP;
          end else begin
            cnt_d   = CNT_W'(LKUP_TMO - 1);
            state_d = LOOKUP;
          end
        end
      end

      LOOKUP: begin
        lookup_req  = 1'b1;
        lookup_addr = hold_q.addr;
        if (lookup_ack) begin
          // Anything other than a legal S/E/M encoding is treated as invalid.
          case (lookup_state)
            MESI_S, MESI_E, MESI_M: res_d = lookup_state;
            default:                res_d = MESI_I;
          endcase
          state_d = RESP;
        end else if (cnt_q == '0) begin
          err_d   = 1'b1;
          res_d   = MESI_I;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      RESP: begin
        res_code    = hold_q.own ? NOHIT : snoop_result(hold_q.op, res_q);
        c_out       = res_code;
        c_out_valid = 1'b1;
        if (!hold_q.own && res_q != MESI_I) begin
          nmsg_valid = 1'b1;
          nmsg_out   = snoop_nmsg(hold_q.op);
        end
        if (res_code == HITM) begin
          cnt_d   = CNT_W'(WB_TMO - 1);
          state_d = WAITWB;
        end else begin
          state_d = IDLE;
        end
      end

      WAITWB: begin
        if (wb_done) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State, held snoop, captured line state, timer and sticky error.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= IDLE;
      hold_q  <= '0;
      res_q   <= MESI_I;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_cache_snoop_responder.sv
// Scoreboard bench for cache_snoop_responder: expected responses are queued
// when a snoop is accepted and compared when c_out_valid fires.
module tb_cache_snoop_responder;
  import Cache_struct::*;

  logic        clk = 1'b0;
  logic        rstb = 1'b0;
  logic        snp_valid;
  logic        snp_ready;
  bus_struct   snp_op;
  logic [31:0] snp_addr;
  logic        snp_own;
  logic        lookup_req;
  logic [31:0] lookup_addr;
  logic        lookup_ack;
  mesi_struct  lookup_state;
  logic [1:0]  c_out;
  logic        c_out_valid;
  n_struct     nmsg_out;
  logic        nmsg_valid;
  logic        wb_done;
  logic        busy;
  logic        err;

  typedef struct {
    logic [1:0] c;
    logic       nv;
    n_struct    n;
  } exp_t;

  typedef struct {
    mesi_struct  st;
    logic [31:0] addr;
  } lk_t;

  exp_t sb_q[$];
  lk_t  lk_q[$];
  exp_t me;
  lk_t  rl;

  int   n_checks = 0;
  int   n_pass = 0;
  int   lk_cnt = 0;
  int   last_run = 0;
  int   ack_delay = 2;
  logic ack_en = 1'b1;

  cache_snoop_responder #(
    .ADDR_W     (32),
    .FIFO_DEPTH (2),
    .LKUP_TMO   (8),
    .WB_TMO     (16)
  ) dut (
    .clk          (clk),
    .rstb         (rstb),
    .snp_valid    (snp_valid),
    .snp_ready    (snp_ready),
    .snp_op       (snp_op),
    .snp_addr     (snp_addr),
    .snp_own      (snp_own),
    .lookup_req   (lookup_req),
    .lookup_addr  (lookup_addr),
    .lookup_ack   (lookup_ack),
    .lookup_state (lookup_state),
    .c_out        (c_out),
    .c_out_valid  (c_out_valid),
    .nmsg_out     (nmsg_out),
    .nmsg_valid   (nmsg_valid),
    .wb_done      (wb_done),
    .busy         (busy),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [1:0] m_cout(bus_struct op, mesi_struct st, logic own);
    if (own) return 2'b10;
    if (op == READ || op == RWIM) begin
      if (st == MESI_M) return 2'b01;
      if (st == MESI_E || st == MESI_S) return 2'b00;
    end
    return 2'b10;
  endfunction

  function automatic n_struct m_nmsg(bus_struct op);
    case (op)
      READ:       return SNOOP_READ_REQ;
      RWIM:       return SNOOP_READ_WITH_M;
      WRITE:      return SNOOP_WRITE_REQ;
      INVALIDATE: return SNOOP_INVALID_CMD;
      default:    return NMSG_NULL;
    endcase
  endfunction

  // Called at posedge+1; returns at posedge+1 of the cycle after the transfer.
  task automatic send(input bus_struct op, input logic [31:0] addr, input logic own,
                      input mesi_struct st, input logic acked);
    exp_t       e;
    lk_t        l;
    mesi_struct eff;
    int         w;
    w = 0;
    snp_valid = 1'b1;
    snp_op    = op;
    snp_addr  = addr;
    snp_own   = own;
    while (!snp_ready && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    if (!snp_ready) begin
      check("send_ready", snp_ready, 1);
      snp_valid = 1'b0;
      return;
    end
    eff  = acked ? st : MESI_I;
    e.c  = m_cout(op, eff, own);
    e.nv = !own && (eff != MESI_I);
    e.n  = m_nmsg(op);
    sb_q.push_back(e);
    if (!own && acked) begin
      l.st   = st;
      l.addr = addr;
      lk_q.push_back(l);
    end
    @(posedge clk); #1;
    snp_valid = 1'b0;
    snp_op    = NULL;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || sb_q.size() != 0) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy || sb_q.size() != 0) check("idle_tmo", {busy, sb_q.size() != 0}, 0);
  endtask

  task automatic wait_cv();
    int n;
    n = 0;
    while (!c_out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!c_out_valid) check("resp_tmo", c_out_valid, 1);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_ready"},  snp_ready, 0);
    check({pfx, "_lreq"},   lookup_req, 0);
    check({pfx, "_laddr"},  lookup_addr, 0);
    check({pfx, "_cout"},   c_out, 2'b10);
    check({pfx, "_cval"},   c_out_valid, 0);
    check({pfx, "_nmsg"},   nmsg_out, NMSG_NULL);
    check({pfx, "_nval"},   nmsg_valid, 0);
    check({pfx, "_busy"},   busy, 0);
    check({pfx, "_err"},    err, 0);
  endtask

  // Lookup agent: acks the lookup ack_delay cycles after lookup_req rises.
  initial begin
    lookup_ack   = 1'b0;
    lookup_state = MESI_I;
    forever begin
      @(posedge clk); #1;
      lookup_ack = 1'b0;
      if (!rstb) begin
        lk_cnt = 0;
      end else if (lookup_req) begin
        lk_cnt++;
        if (ack_en && lk_cnt == ack_delay + 1 && lk_q.size() > 0) begin
          rl = lk_q.pop_front();
          check("lookup_addr", lookup_addr, rl.addr);
          lookup_state = rl.st;
          lookup_ack   = 1'b1;
        end
      end else begin
        if (lk_cnt != 0) last_run = lk_cnt;
        lk_cnt = 0;
      end
    end
  end

  // Response monitor: pops the scoreboard on each c_out_valid pulse.
  always @(negedge clk) begin
    if (rstb) begin
      if (nmsg_valid && !c_out_valid) check("nmsg_qual", nmsg_valid, 0);
      if (c_out_valid) begin
        if (sb_q.size() == 0) begin
          check("resp_expected", c_out_valid, 0);
        end else begin
          me = sb_q.pop_front();
          check("c_out", c_out, me.c);
          check("nmsg_valid", nmsg_valid, me.nv);
          if (me.nv) check("nmsg_out", nmsg_out, me.n);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    snp_valid = 1'b0;
    snp_op    = NULL;
    snp_addr  = '0;
    snp_own   = 1'b0;
    wb_done   = 1'b0;
    #1;
    check_reset_outputs("rst");
    repeat (3) @(posedge clk);
    #1 rstb = 1'b1;
    @(posedge clk); #1;
    check("rst_ready_after", snp_ready, 1);

    // READ, state E, ack two cycles after lookup_req
    send(READ, 32'h1000, 1'b0, MESI_E, 1'b1);
    check("t1_req_t1", lookup_req, 0);
    @(posedge clk); #1;
    check("t1_req_t2", lookup_req, 1);
    check("t1_addr_t2", lookup_addr, 32'h1000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t1_cval_a", c_out_valid, 0);
    @(posedge clk); #1;
    check("t1_cval_a1", c_out_valid, 1);
    @(posedge clk); #1;
    check("t1_cval_pulse", c_out_valid, 0);
    check("t1_idle", busy, 0);

    // RWIM hits M; a queued READ waits for the flush write
    send(RWIM, 32'h2040, 1'b0, MESI_M, 1'b1);
    send(READ, 32'h3000, 1'b0, MESI_S, 1'b1);
    wait_cv();
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("t2_wait_busy", busy, 1);
      check("t2_wait_noreq", lookup_req, 0);
    end
    wb_done = 1'b1;
    @(posedge clk); #1;
    wb_done = 1'b0;
    check("t2_pop_noreq", lookup_req, 0);
    @(posedge clk); #1;
    check("t2_req_after", lookup_req, 1);
    check("t2_addr_after", lookup_addr, 32'h3000);
    wait_idle();

    // INVALIDATE on S and on I, WRITE on E
    send(INVALIDATE, 32'h4000, 1'b0, MESI_S, 1'b1);
    send(INVALIDATE, 32'h4040, 1'b0, MESI_I, 1'b1);
    send(WRITE,      32'h4080, 1'b0, MESI_E, 1'b1);
    wait_idle();

    // own READ: no lookup, result at T+2
    send(READ, 32'h1000, 1'b1, MESI_M, 1'b1);
    check("t4_cval_t1", c_out_valid, 0);
    check("t4_req_t1", lookup_req, 0);
    @(posedge clk); #1;
    check("t4_cval_t2", c_out_valid, 1);
    check("t4_req_t2", lookup_req, 0);
    wait_idle();

    // lookup timeout with a full queue behind it
    ack_en = 1'b0;
    send(READ,  32'h6000, 1'b0, MESI_M, 1'b0);
    send(RWIM,  32'h6040, 1'b0, MESI_E, 1'b1);
    send(WRITE, 32'h6080, 1'b0, MESI_S, 1'b1);
    check("t5_full_ready", snp_ready, 0);
    check("t5_err_pre", err, 0);
    for (int i = 0; i < 50 && !err; i++) @(negedge clk);
    check("t5_err", err, 1);
    check("t5_lkup_run", last_run, 8);
    ack_en = 1'b1;
    @(posedge clk); #1;
    send(READ, 32'h60C0, 1'b0, MESI_S, 1'b1);
    wait_idle();
    check("t5_err_sticky", err, 1);

    // reset while waiting for a flush write
    send(RWIM, 32'h7000, 1'b0, MESI_M, 1'b1);
    send(READ, 32'h7040, 1'b0, MESI_E, 1'b1);
    wait_cv();
    @(posedge clk); #3;
    rstb = 1'b0;
    sb_q.delete();
    lk_q.delete();
    #1;
    check_reset_outputs("t6");
    @(posedge clk);
    @(posedge clk); #1;
    rstb = 1'b1;
    @(posedge clk); #1;
    check("t6_ready_after", snp_ready, 1);
    check("t6_busy_after", busy, 0);
    send(READ, 32'h7080, 1'b0, MESI_E, 1'b1);
    wait_idle();
    check("t6_err_clear", err, 0);

    // flush write never arrives: error after WB_TMO cycles in WAITWB
    send(RWIM, 32'h5000, 1'b0, MESI_M, 1'b1);
    wait_cv();
    repeat (16) begin
      @(posedge clk); #1;
    end
    check("t7_err_before", err, 0);
    check("t7_busy_before", busy, 1);
    @(posedge clk); #1;
    check("t7_err_after", err, 1);
    check("t7_idle_after", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
